// File: rtl/fetch_decode_receiver.sv
// Receive side of the fetch-to-decode link: consumes packets from a busy-flag bus into a
// small circular buffer and presents the head entry to decode with a valid/ready handshake.
module fetch_decode_receiver #(
    parameter int PKT_W = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     bus_is_busy,
    input  logic [PKT_W-1:0]         bus_data,
    output logic                     bus_recv,
    input  logic                     flush,
    output logic                     out_valid,
    output logic [PKT_W-1:0]         out_data,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic [31:0]              rx_total,
    output logic                     proto_err
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [0:0] ST_RUN     = 1'b0;
    localparam logic [0:0] ST_DISCARD = 1'b1;

    localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [0:0]       state_q, state_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [31:0]      rx_total_q, rx_total_d;
    logic             proto_err_q, proto_err_d;
    logic             busy_prev_q, recv_prev_q;
    logic [PKT_W-1:0] mem_q [DEPTH];

    logic full;
    logic enq;
    logic deq;

    assign full      = (count_q == DEPTH_C);
    assign out_valid = !reset && (state_q == ST_RUN) && (count_q != '0);
    assign out_data  = mem_q[rd_ptr_q];
    assign count     = count_q;
    assign rx_total  = rx_total_q;
    assign proto_err = proto_err_q;

    // A full buffer can still take a packet when the head leaves in the same cycle.
    always_comb begin
        bus_recv = 1'b0;
        if (!reset) begin
            if (state_q == ST_RUN) begin
                bus_recv = bus_is_busy && !flush && (!full || (out_valid && out_ready));
            end else begin
                bus_recv = bus_is_busy;
            end
        end
    end

    assign enq = bus_recv && (state_q == ST_RUN);
    assign deq = out_valid && out_ready && !flush;

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        rx_total_d  = rx_total_q;
        proto_err_d = proto_err_q | (busy_prev_q && !bus_is_busy && !recv_prev_q);
        if (flush) begin
            state_d  = ST_DISCARD;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            state_d = ST_RUN;
            if (enq) begin
                wr_ptr_d   = wr_ptr_q + PTR_ONE;
                rx_total_d = rx_total_q + 32'd1;
            end
            if (deq) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            case ({enq, deq})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_RUN;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rx_total_q  <= '0;
            proto_err_q <= 1'b0;
            busy_prev_q <= 1'b0;
            recv_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rx_total_q  <= rx_total_d;
            proto_err_q <= proto_err_d;
            busy_prev_q <= bus_is_busy;
            recv_prev_q <= bus_recv;
        end
    end

    // Storage carries no reset so it maps onto distributed/block RAM.
    always_ff @(posedge clk) begin
        if (enq) begin
            mem_q[wr_ptr_q] <= bus_data;
        end
    end

endmodule

// File: tb/tb_fetch_decode_receiver.sv
// Self-checking bench for fetch_decode_receiver: a cycle-vector table with a data scoreboard,
// followed by a randomised streaming run driven by a simple bus model.
module tb_fetch_decode_receiver;

    logic        clk = 1'b0;
    logic        reset;
    logic        bus_is_busy;
    logic [63:0] bus_data;
    logic        bus_recv;
    logic        flush;
    logic        out_valid;
    logic [63:0] out_data;
    logic        out_ready;
    logic [2:0]  count;
    logic [31:0] rx_total;
    logic        proto_err;

    int n_checks = 0;
    int n_errors = 0;

    fetch_decode_receiver #(.PKT_W(64), .DEPTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus_is_busy(bus_is_busy),
        .bus_data   (bus_data),
        .bus_recv   (bus_recv),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .count      (count),
        .rx_total   (rx_total),
        .proto_err  (proto_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        busy;
        logic        flush;
        logic        ready;
        logic [63:0] data;
        logic        exp_recv;
        logic        exp_valid;
        logic [2:0]  exp_count;
        logic [31:0] exp_rx;
        logic        exp_err;
        logic        exp_enq;
    } vec_t;

    vec_t        vecs[$];
    logic [63:0] sbq[$];

    function automatic vec_t mk(input logic rst, input logic busy, input logic flsh,
                                input logic rdy, input logic [63:0] data,
                                input logic e_recv, input logic e_valid, input int e_cnt,
                                input int e_rx, input logic e_err, input logic e_enq);
        vec_t v;
        v.rst = rst; v.busy = busy; v.flush = flsh; v.ready = rdy; v.data = data;
        v.exp_recv = e_recv; v.exp_valid = e_valid; v.exp_count = 3'(e_cnt);
        v.exp_rx = 32'(e_rx); v.exp_err = e_err; v.exp_enq = e_enq;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    initial begin
        logic [63:0] p1;
        int          sent;
        int          popped;
        int          cyc;
        logic        pending;
        logic        recv_s;

        p1 = 64'h0000_1000_0000_0013;

        // rst busy flush ready data | recv valid count rx err enq
        vecs.push_back(mk(1, 1, 0, 0, 64'h0,  0, 0, 0, 0, 0, 0));
        // single packet
        vecs.push_back(mk(0, 1, 0, 0, p1,     1, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 64'h0,  0, 1, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 64'h0,  0, 1, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 64'h0,  0, 0, 0, 1, 0, 0));
        // fill to full, back-pressure, then accept the 5th on a dequeue
        vecs.push_back(mk(0, 1, 0, 0, 64'hA1, 1, 0, 0, 1, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0, 64'hA2, 1, 1, 1, 2, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0, 64'hA3, 1, 1, 2, 3, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0, 64'hA4, 1, 1, 3, 4, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0, 64'hA5, 0, 1, 4, 5, 0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 64'hA5, 1, 1, 4, 5, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 64'h0,  0, 1, 4, 6, 0, 0));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(0, 0, 0, 1, 64'h0, 0, 1, 4 - i, 6, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 64'h0,  0, 0, 0, 6, 0, 0));
        // ten-packet stream with ready held high: pointers wrap
        for (int i = 0; i < 10; i++)
            vecs.push_back(mk(0, 1, 0, 1, 64'hB0 + 64'(i), 1, (i > 0), (i > 0) ? 1 : 0,
                              6 + i, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 64'h0,  0, 1, 1, 16, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 64'h0,  0, 0, 0, 16, 0, 0));
        // flush at count=3 with a packet pending on the bus
        vecs.push_back(mk(0, 1, 0, 0, 64'hC0, 1, 0, 0, 16, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0, 64'hC1, 1, 1, 1, 17, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0, 64'hC2, 1, 1, 2, 18, 0, 1));
        vecs.push_back(mk(0, 1, 1, 1, 64'hC3, 0, 1, 3, 19, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 64'hC3, 1, 0, 0, 19, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 64'h0,  0, 0, 0, 19, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 64'hD0, 1, 0, 0, 19, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 64'h0,  0, 1, 1, 20, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 64'h0,  0, 0, 0, 20, 0, 0));
        // back-to-back flush re-enters DISCARD, so E1 is also dropped
        vecs.push_back(mk(0, 0, 1, 0, 64'h0,  0, 0, 0, 20, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 64'hE0, 1, 0, 0, 20, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 64'hE1, 1, 0, 0, 20, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 64'h0,  0, 0, 0, 20, 0, 0));
        // busy falls without a consume: sticky protocol error
        vecs.push_back(mk(0, 1, 1, 0, 64'hF0, 0, 0, 0, 20, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 64'h0,  0, 0, 0, 20, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 64'h0,  0, 0, 0, 20, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 64'h0,  0, 0, 0, 20, 1, 0));
        // reset with count=2 overrides a simultaneous flush/enqueue/dequeue
        vecs.push_back(mk(0, 1, 0, 0, 64'h60, 1, 0, 0, 20, 1, 1));
        vecs.push_back(mk(0, 1, 0, 0, 64'h61, 1, 1, 1, 21, 1, 1));
        vecs.push_back(mk(1, 1, 1, 1, 64'h62, 0, 0, 2, 22, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 64'h62, 1, 0, 0, 0,  0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 64'h0,  0, 1, 1, 1,  0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 64'h0,  0, 0, 0, 1,  0, 0));

        reset = 1'b1; bus_is_busy = 1'b0; bus_data = '0; flush = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1;
            reset       = vecs[i].rst;
            bus_is_busy = vecs[i].busy;
            flush       = vecs[i].flush;
            out_ready   = vecs[i].ready;
            bus_data    = vecs[i].data;
            @(negedge clk);
            $display("vec %0d: recv=%b valid=%b count=%0d rx_total=%0d proto_err=%b",
                     i, bus_recv, out_valid, count, rx_total, proto_err);
            chk("bus_recv",  i, 64'(bus_recv),  64'(vecs[i].exp_recv));
            chk("out_valid", i, 64'(out_valid), 64'(vecs[i].exp_valid));
            chk("count",     i, 64'(count),     64'(vecs[i].exp_count));
            chk("rx_total",  i, 64'(rx_total),  64'(vecs[i].exp_rx));
            chk("proto_err", i, 64'(proto_err), 64'(vecs[i].exp_err));
            if (vecs[i].exp_valid) begin
                if (sbq.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL scoreboard_empty[%0d]: got empty queue required an entry", i);
                end else begin
                    chk("out_data", i, out_data, sbq[0]);
                end
            end
            if (vecs[i].rst || vecs[i].flush) begin
                sbq.delete();
            end else begin
                if (vecs[i].exp_valid && vecs[i].ready && sbq.size() > 0) void'(sbq.pop_front());
                if (vecs[i].exp_enq) sbq.push_back(vecs[i].data);
            end
        end

        // Randomised stream: the bus model holds each packet until it is consumed.
        sent = 0; popped = 0; cyc = 0; pending = 1'b0; recv_s = 1'b0;
        sbq.delete();
        while (popped < 20 && cyc < 3000) begin
            @(posedge clk);
            #1;
            if (recv_s) begin
                sbq.push_back(bus_data);
                pending     = 1'b0;
                bus_is_busy = 1'b0;
            end
            if (!pending && sent < 20 && $urandom_range(0, 2) != 0) begin
                bus_data    = {$urandom, $urandom};
                bus_is_busy = 1'b1;
                pending     = 1'b1;
                sent++;
            end
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            recv_s = bus_recv;
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL stream_underflow[%0d]: got output with empty queue required none", popped);
                end else begin
                    $display("stream pop %0d: data=%h", popped, out_data);
                    chk("stream_data", popped, out_data, sbq.pop_front());
                end
                popped++;
            end
            cyc++;
        end
        chk("stream_timeout", cyc, 64'(popped), 64'd20);
        @(posedge clk);
        #1;
        bus_is_busy = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        chk("stream_count",     0, 64'(count),     64'd0);
        chk("stream_rx_total",  0, 64'(rx_total),  64'd21);
        chk("stream_proto_err", 0, 64'(proto_err), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fetch_decode_receiver.md
FETCH_DECODE_RECEIVER -- requirements
Module: fetch_decode_receiver

Interface
REQ-001 The block SHALL have parameter PKT_W, default 64: width of one fetch-to-decode packet (PC in upper half, instruction word in lower half).
REQ-002 The block SHALL have parameter DEPTH, default 4, power of two, minimum 2: number of receive-buffer entries.
REQ-003 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1: reset, synchronous and active-high.
REQ-005 Port bus_is_busy, input, 1: bus occupancy flag; 1 = packet pending on bus_data.
REQ-006 Port bus_data, input, PKT_W: packet held on the bus.
REQ-007 Port bus_recv, output, 1: one-cycle consume strobe; the bus clears is_busy at the same clock edge.
REQ-008 Port flush, input, 1: pipeline redirect; discard buffered and in-flight packets.
REQ-009 Port out_valid, output, 1: head buffer entry valid.
REQ-010 Port out_data, output, PKT_W: head buffer entry.
REQ-011 Port out_ready, input, 1: decode accepts the head entry this cycle.
REQ-012 Port count, output, $clog2(DEPTH)+1: number of occupied entries.
REQ-013 Port rx_total, output, 32: packets enqueued since reset; wraps modulo 2^32.
REQ-014 Port proto_err, output, 1: sticky protocol-violation flag.

Function
REQ-015 Buffer SHALL be a circular FIFO: read/write pointers of $clog2(DEPTH) bits, wrapping from DEPTH-1 to 0.
REQ-016 FSM states SHALL be RUN and DISCARD.
REQ-017 In RUN, bus_recv SHALL be combinational: bus_is_busy && !flush && (count < DEPTH || (out_valid && out_ready)).
REQ-018 A bus_recv cycle in RUN SHALL write bus_data at the write pointer, advance the write pointer, and increment rx_total.
REQ-019 Enqueue latency SHALL be one cycle: a packet consumed in cycle N is visible on out_data in cycle N+1 when the buffer was empty.
REQ-020 out_valid SHALL equal (count != 0); out_data SHALL be the entry at the read pointer, driven combinationally from registers.
REQ-021 out_valid && out_ready SHALL advance the read pointer; out_ready while out_valid=0 SHALL have no effect.
REQ-022 A simultaneous enqueue and dequeue SHALL leave count unchanged; full with a dequeue SHALL accept the new packet.
REQ-023 Full without a dequeue SHALL hold bus_recv=0; the packet stays on the bus (back-pressure).
REQ-024 When flush=1 in any state, at that edge the block SHALL set both pointers and count to 0 and enter DISCARD; no enqueue or dequeue SHALL take effect in that cycle.
REQ-025 In DISCARD, bus_recv SHALL equal bus_is_busy; a consumed packet SHALL be dropped (not enqueued, rx_total unchanged).
REQ-026 DISCARD SHALL return to RUN after exactly one cycle unless flush=1 again, which SHALL re-enter DISCARD.
REQ-027 out_valid SHALL be 0 in DISCARD.
REQ-028 proto_err SHALL set when bus_is_busy falls 1->0 without bus_recv having been 1 in the previous cycle.
REQ-029 Once set, proto_err SHALL stay 1 until reset.

Reset
REQ-030 On reset=1 at a rising edge, the block SHALL set: state RUN, pointers 0, count 0, rx_total 0, proto_err 0.
REQ-031 While reset=1, bus_recv SHALL be 0 and out_valid SHALL be 0.
REQ-032 Reset SHALL override a simultaneous flush, enqueue or dequeue.
REQ-033 Buffer storage SHALL NOT require reset; out_data is don't-care while out_valid=0.
REQ-034 The cycle after reset deasserts SHALL be a normal RUN cycle.

Verification
REQ-035 Single packet: bus_is_busy=1, bus_data=0x0000_1000_0000_0013 for one cycle, out_ready=0 -> bus_recv=1 that cycle; next cycle out_valid=1, out_data=0x0000_1000_0000_0013, count=1, rx_total=1.
REQ-036 Fill and back-pressure: 5 back-to-back packets, out_ready=0, DEPTH=4 -> 4 consumed; bus_recv=0 while 5th pending; count=4; one out_ready pulse -> 5th consumed the same cycle, count stays 4.
REQ-037 Wrap-around: stream 10 packets with out_ready=1 throughout -> outputs in order, pointers wrap, rx_total=10, count=0 at end.
REQ-038 Flush with pending bus packet: count=3, flush=1 with bus_is_busy=1 -> next cycle count=0, out_valid=0, bus_recv=1, packet dropped; rx_total unchanged; RUN the following cycle.
REQ-039 Protocol error: bus_is_busy 1->0 with bus_recv=0 the cycle before -> proto_err=1 next cycle, held until reset.
REQ-040 Reset mid-stream: reset=1 with count=2 and flush=1 -> next cycle count=0, rx_total=0, proto_err=0, bus_recv=0, state RUN.
